// File: rtl/cpu_pkg.sv
// Shared encodings for the 16-bit CPU: states, opcodes, ALU selects.
// Also used by the datapath and the benches.
package cpu_pkg;

  typedef enum logic [4:0] {
    S_FETCH0 = 5'd0,
    S_FETCH1 = 5'd1,
    S_FETCH2 = 5'd2,
    S_FETCH3 = 5'd3,
    S_DECODE = 5'd4,
    S_ALU1   = 5'd5,
    S_ALU2   = 5'd6,
    S_LD1    = 5'd7,
    S_LD2    = 5'd8,
    S_LD3    = 5'd9,
    S_LD4    = 5'd10,
    S_ST1    = 5'd11,
    S_ST2    = 5'd12,
    S_ST3    = 5'd13,
    S_ST4    = 5'd14,
    S_BR1    = 5'd15,
    S_BR2    = 5'd16,
    S_JMP1   = 5'd17,
    S_HALT   = 5'd31
  } state_e;

  localparam logic [6:0] OP_ADD = 7'h00;
  localparam logic [6:0] OP_SUB = 7'h01;
  localparam logic [6:0] OP_AND = 7'h02;
  localparam logic [6:0] OP_OR  = 7'h03;
  localparam logic [6:0] OP_XOR = 7'h04;
  localparam logic [6:0] OP_NOT = 7'h05;
  localparam logic [6:0] OP_LD  = 7'h10;
  localparam logic [6:0] OP_ST  = 7'h11;
  localparam logic [6:0] OP_BZ  = 7'h20;
  localparam logic [6:0] OP_BNZ = 7'h21;
  localparam logic [6:0] OP_BC  = 7'h22;
  localparam logic [6:0] OP_BV  = 7'h23;
  localparam logic [6:0] OP_BS  = 7'h24;
  localparam logic [6:0] OP_JMP = 7'h28;
  localparam logic [6:0] OP_HLT = 7'h7F;

  localparam logic [2:0] FSEL_ADD   = 3'd0;
  localparam logic [2:0] FSEL_SUB   = 3'd1;
  localparam logic [2:0] FSEL_AND   = 3'd2;
  localparam logic [2:0] FSEL_OR    = 3'd3;
  localparam logic [2:0] FSEL_XOR   = 3'd4;
  localparam logic [2:0] FSEL_NOT   = 3'd5;
  localparam logic [2:0] FSEL_PASSX = 3'd6;
  localparam logic [2:0] FSEL_INC   = 3'd7;

  typedef struct packed {
    logic c;
    logic v;
    logic s;
    logic z;
  } flags_t;

  typedef struct packed {
    logic       ld_pc;
    logic       ld_ir;
    logic       ld_mar;
    logic       rd_mem;
    logic       wr_mem;
    logic       ld_tmp;
    logic       ld_mdrz;
    logic       ld_mdrdata;
    logic       wr_reg;
    logic       rd_reg;
    logic       ld_alu;
    logic       ld_xpc;
    logic       ld_xtmp;
    logic       ld_ytmp;
    logic       ld_xreg;
    logic       ld_yreg;
    logic [2:0] wr_rega;
    logic [2:0] rd_rega;
    logic [2:0] fsel;
  } ctl_t;

  function automatic logic is_alu_op(input logic [6:0] opc);
    return opc <= OP_NOT;
  endfunction

  function automatic logic is_branch_op(input logic [6:0] opc);
    return opc inside {OP_BZ, OP_BNZ, OP_BC, OP_BV, OP_BS};
  endfunction

endpackage

// File: rtl/cpu_branch_cond.sv
// Branch decision from the captured flag register.
// Non-branch opcodes always report not taken.
module cpu_branch_cond
  import cpu_pkg::*;
(
  input  logic [6:0] opc,
  input  flags_t     flags,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (opc)
      OP_BZ:   taken = flags.z;
      OP_BNZ:  taken = ~flags.z;
      OP_BC:   taken = flags.c;
      OP_BV:   taken = flags.v;
      OP_BS:   taken = flags.s;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle Moore controller: owns the CPU state and flag registers
// and decodes every datapath strobe from the current state.
module cpu_control_unit
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opc,
  input  logic [2:0] opd1,
  input  logic [2:0] opd2,
  input  logic [2:0] opd3,
  input  logic       C,
  input  logic       V,
  input  logic       S,
  input  logic       Z_det,
  output logic       ldPC,
  output logic       ldIR,
  output logic       ldMAR,
  output logic       rd_mem,
  output logic       wr_mem,
  output logic       ldtmp,
  output logic       ldMDRZ,
  output logic       ldMDRdata,
  output logic       wr_reg,
  output logic       rd_reg,
  output logic       ldALU,
  output logic       ldXPC,
  output logic       ldYPC,
  output logic       ldXtmp,
  output logic       ldYtmp,
  output logic       ldXreg,
  output logic       ldYreg,
  output logic       ldXmem,
  output logic       ldYmem,
  output logic       ldXtmp2,
  output logic       ldYtmp2,
  output logic [2:0] wr_regA,
  output logic [2:0] rd_regA,
  output logic [2:0] fsel,
  output logic [4:0] state,
  output logic [4:0] next_state,
  output logic       halted,
  output logic       illegal_op
);

  state_e state_q, state_d;
  flags_t flags_q, flags_d;
  logic   illegal_q, illegal_d;
  logic   taken;
  ctl_t   ctl, ctl_o;

  cpu_branch_cond u_br (
    .opc   (opc),
    .flags (flags_q),
    .taken (taken)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH0;
      flags_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    ctl       = '0;
    state_d   = state_q;
    flags_d   = flags_q;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH0: begin
        ctl.ld_xpc = 1'b1;
        ctl.fsel   = FSEL_PASSX;
        ctl.ld_alu = 1'b1;
        state_d    = S_FETCH1;
      end
      S_FETCH1: begin
        ctl.ld_mar = 1'b1;
        ctl.rd_mem = 1'b1;
        state_d    = S_FETCH2;
      end
      S_FETCH2: begin
        ctl.rd_mem     = 1'b1;
        ctl.ld_mdrdata = 1'b1;
        ctl.ld_xpc     = 1'b1;
        ctl.fsel       = FSEL_INC;
        ctl.ld_alu     = 1'b1;
        state_d        = S_FETCH3;
      end
      S_FETCH3: begin
        ctl.ld_ir = 1'b1;
        ctl.ld_pc = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        ctl.rd_reg  = 1'b1;
        ctl.rd_rega = opd2;
        ctl.ld_tmp  = 1'b1;
        unique case (1'b1)
          is_alu_op(opc):    state_d = S_ALU1;
          opc == OP_LD:      state_d = S_LD1;
          opc == OP_ST:      state_d = S_ST1;
          opc == OP_JMP:     state_d = S_JMP1;
          opc == OP_HLT:     state_d = S_HALT;
          is_branch_op(opc): state_d = taken ? S_BR1 : S_FETCH0;
          default: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_ALU1: begin
        ctl.rd_reg  = 1'b1;
        ctl.rd_rega = opd3;
        ctl.ld_xtmp = 1'b1;
        ctl.ld_yreg = 1'b1;
        ctl.fsel    = opc[2:0];
        ctl.ld_alu  = 1'b1;
        state_d     = S_ALU2;
      end
      S_ALU2: begin
        ctl.wr_reg  = 1'b1;
        ctl.wr_rega = opd1;
        flags_d     = '{c: C, v: V, s: S, z: Z_det};
        state_d     = S_FETCH0;
      end
      S_LD1, S_ST1, S_JMP1: begin
        ctl.ld_xtmp = 1'b1;
        ctl.fsel    = FSEL_PASSX;
        ctl.ld_alu  = 1'b1;
        state_d     = (state_q == S_LD1)  ? S_LD2 :
                      (state_q == S_ST1)  ? S_ST2 : S_BR2;
      end
      S_LD2: begin
        ctl.ld_mar = 1'b1;
        ctl.rd_mem = 1'b1;
        state_d    = S_LD3;
      end
      S_LD3: begin
        ctl.rd_mem     = 1'b1;
        ctl.ld_mdrdata = 1'b1;
        state_d        = S_LD4;
      end
      S_LD4: begin
        ctl.wr_reg  = 1'b1;
        ctl.wr_rega = opd1;
        state_d     = S_FETCH0;
      end
      S_ST2: begin
        ctl.ld_mar  = 1'b1;
        ctl.rd_reg  = 1'b1;
        ctl.rd_rega = opd1;
        ctl.ld_xreg = 1'b1;
        ctl.fsel    = FSEL_PASSX;
        ctl.ld_alu  = 1'b1;
        state_d     = S_ST3;
      end
      S_ST3: begin
        ctl.ld_mdrz = 1'b1;
        state_d     = S_ST4;
      end
      S_ST4: begin
        ctl.wr_mem = 1'b1;
        state_d    = S_FETCH0;
      end
      S_BR1: begin
        ctl.ld_xpc  = 1'b1;
        ctl.ld_ytmp = 1'b1;
        ctl.fsel    = FSEL_ADD;
        ctl.ld_alu  = 1'b1;
        state_d     = S_BR2;
      end
      S_BR2: begin
        ctl.ld_pc = 1'b1;
        state_d   = S_FETCH0;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH0;
    endcase
  end

  // Reset masks every strobe so an abandoned LD/ST never writes.
  assign ctl_o = reset ? '0 : ctl;

  assign ldPC      = ctl_o.ld_pc;
  assign ldIR      = ctl_o.ld_ir;
  assign ldMAR     = ctl_o.ld_mar;
  assign rd_mem    = ctl_o.rd_mem;
  assign wr_mem    = ctl_o.wr_mem;
  assign ldtmp     = ctl_o.ld_tmp;
  assign ldMDRZ    = ctl_o.ld_mdrz;
  assign ldMDRdata = ctl_o.ld_mdrdata;
  assign wr_reg    = ctl_o.wr_reg;
  assign rd_reg    = ctl_o.rd_reg;
  assign ldALU     = ctl_o.ld_alu;
  assign ldXPC     = ctl_o.ld_xpc;
  assign ldXtmp    = ctl_o.ld_xtmp;
  assign ldYtmp    = ctl_o.ld_ytmp;
  assign ldXreg    = ctl_o.ld_xreg;
  assign ldYreg    = ctl_o.ld_yreg;
  assign wr_regA   = ctl_o.wr_rega;
  assign rd_regA   = ctl_o.rd_rega;
  assign fsel      = ctl_o.fsel;
  assign ldYPC     = 1'b0;
  assign ldXmem    = 1'b0;
  assign ldYmem    = 1'b0;
  assign ldXtmp2   = 1'b0;
  assign ldYtmp2   = 1'b0;

  assign state      = state_q;
  assign next_state = reset ? 5'd0 : state_d;
  assign halted     = ~reset & (state_q == S_HALT);
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: directed program plus random
// instruction stream against an instruction-level reference model.
module tb_cpu_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opc;
  logic [2:0] opd1, opd2, opd3;
  logic       C, V, S, Z_det;
  logic       ldPC, ldIR, ldMAR, rd_mem, wr_mem, ldtmp, ldMDRZ;
  logic       ldMDRdata, wr_reg, rd_reg, ldALU;
  logic       ldXPC, ldYPC, ldXtmp, ldYtmp, ldXreg, ldYreg;
  logic       ldXmem, ldYmem, ldXtmp2, ldYtmp2;
  logic [2:0] wr_regA, rd_regA, fsel;
  logic [4:0] state, next_state;
  logic       halted, illegal_op;

  cpu_control_unit dut (
    .clk(clk), .reset(reset), .opc(opc),
    .opd1(opd1), .opd2(opd2), .opd3(opd3),
    .C(C), .V(V), .S(S), .Z_det(Z_det),
    .ldPC(ldPC), .ldIR(ldIR), .ldMAR(ldMAR),
    .rd_mem(rd_mem), .wr_mem(wr_mem), .ldtmp(ldtmp),
    .ldMDRZ(ldMDRZ), .ldMDRdata(ldMDRdata),
    .wr_reg(wr_reg), .rd_reg(rd_reg), .ldALU(ldALU),
    .ldXPC(ldXPC), .ldYPC(ldYPC), .ldXtmp(ldXtmp),
    .ldYtmp(ldYtmp), .ldXreg(ldXreg), .ldYreg(ldYreg),
    .ldXmem(ldXmem), .ldYmem(ldYmem),
    .ldXtmp2(ldXtmp2), .ldYtmp2(ldYtmp2),
    .wr_regA(wr_regA), .rd_regA(rd_regA), .fsel(fsel),
    .state(state), .next_state(next_state),
    .halted(halted), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pc, ir, mar, rdm, wrm, tmp, mdrz, mdrd, wrr, rdr, alu;
    logic xpc, ypc, xtmp, ytmp, xreg, yreg, xmem, ymem, xtmp2, ytmp2;
  } strb_t;

  int total = 0;
  int bad = 0;
  int force_z = -1;
  logic mc, mv, ms, mz, m_ill;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic strb_t obs_strb();
    return '{pc: ldPC, ir: ldIR, mar: ldMAR, rdm: rd_mem, wrm: wr_mem,
             tmp: ldtmp, mdrz: ldMDRZ, mdrd: ldMDRdata, wrr: wr_reg,
             rdr: rd_reg, alu: ldALU, xpc: ldXPC, ypc: ldYPC,
             xtmp: ldXtmp, ytmp: ldYtmp, xreg: ldXreg, yreg: ldYreg,
             xmem: ldXmem, ymem: ldYmem, xtmp2: ldXtmp2, ytmp2: ldYtmp2};
  endfunction

  // Output table straight from the state descriptions.
  task automatic exp_out(input int st, output strb_t s,
                         output logic [2:0] ra, wa, fs);
    s = '0; ra = 3'd0; wa = 3'd0; fs = 3'd0;
    case (st)
      0:  begin s.xpc = 1; s.alu = 1; fs = 3'd6; end
      1:  begin s.mar = 1; s.rdm = 1; end
      2:  begin s.rdm = 1; s.mdrd = 1; s.xpc = 1; s.alu = 1; fs = 3'd7; end
      3:  begin s.ir = 1; s.pc = 1; end
      4:  begin s.rdr = 1; ra = opd2; s.tmp = 1; end
      5:  begin
        s.rdr = 1; ra = opd3; s.xtmp = 1; s.yreg = 1;
        fs = opc[2:0]; s.alu = 1;
      end
      6:  begin s.wrr = 1; wa = opd1; end
      7, 11, 17: begin s.xtmp = 1; fs = 3'd6; s.alu = 1; end
      8:  begin s.mar = 1; s.rdm = 1; end
      9:  begin s.rdm = 1; s.mdrd = 1; end
      10: begin s.wrr = 1; wa = opd1; end
      12: begin
        s.mar = 1; s.rdr = 1; ra = opd1; s.xreg = 1;
        fs = 3'd6; s.alu = 1;
      end
      13: s.mdrz = 1;
      14: s.wrm = 1;
      15: begin s.xpc = 1; s.ytmp = 1; fs = 3'd0; s.alu = 1; end
      16: s.pc = 1;
      default: ;
    endcase
  endtask

  // One clock: drive random live flags, check, then advance.
  task automatic do_cycle(input int st, input int nxt);
    strb_t es;
    logic [2:0] ra, wa, fs;
    {C, V, S, Z_det} = 4'($urandom);
    if (st == 6 && force_z >= 0) Z_det = force_z[0];
    #1;
    exp_out(st, es, ra, wa, fs);
    check("state", 32'(state), 32'(st));
    check("next_state", 32'(next_state), 32'(nxt));
    check("strobes", 32'(obs_strb()), 32'(es));
    check("rd_regA", 32'(rd_regA), 32'(ra));
    check("wr_regA", 32'(wr_regA), 32'(wa));
    check("fsel", 32'(fsel), 32'(fs));
    check("halted", 32'(halted), 32'(st == 31));
    check("illegal_op", 32'(illegal_op), 32'(m_ill));
    check("wr_clash", 32'(wr_mem & wr_reg), 32'd0);
    if (st == 6) begin mc = C; mv = V; ms = S; mz = Z_det; end
    @(negedge clk);
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] d1,
                           input logic [2:0] d2, input logic [2:0] d3);
    int body[$];
    int lat;
    bit tk, hlt, ill;
    opc = o; opd1 = d1; opd2 = d2; opd3 = d3;
    hlt = 0; ill = 0; lat = 0;
    for (int i = 0; i < 4; i++) do_cycle(i, i + 1);
    case (o)
      7'h20: tk = mz;
      7'h21: tk = !mz;
      7'h22: tk = mc;
      7'h23: tk = mv;
      7'h24: tk = ms;
      default: tk = 0;
    endcase
    if (o <= 7'h05) begin body = '{5, 6}; lat = 7; end
    else if (o == 7'h10) begin body = '{7, 8, 9, 10}; lat = 9; end
    else if (o == 7'h11) begin body = '{11, 12, 13, 14}; lat = 9; end
    else if (o >= 7'h20 && o <= 7'h24) begin
      if (tk) begin body = '{15, 16}; lat = 7; end
      else begin body = '{}; lat = 5; end
    end
    else if (o == 7'h28) begin body = '{17, 16}; lat = 7; end
    else begin body = '{31}; hlt = 1; ill = (o != 7'h7F); end
    do_cycle(4, body.size() > 0 ? body[0] : 0);
    if (ill) m_ill = 1;
    for (int k = 0; k < body.size(); k++)
      do_cycle(body[k], k + 1 < body.size() ? body[k + 1] : (hlt ? 31 : 0));
    if (!hlt) check("latency", 32'(5 + body.size()), 32'(lat));
  endtask

  task automatic apply_reset(input int n);
    reset = 1;
    for (int i = 0; i < n; i++) begin
      #1;
      check("rst_strobes", 32'(obs_strb()), 32'd0);
      check("rst_addr_fsel", 32'({rd_regA, wr_regA, fsel}), 32'd0);
      check("rst_next", 32'(next_state), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      @(negedge clk);
      check("rst_state", 32'(state), 32'd0);
      check("rst_illegal", 32'(illegal_op), 32'd0);
    end
    reset = 0;
    {mc, mv, ms, mz} = 4'd0;
    m_ill = 0;
  endtask

  logic [6:0] legal [15] = '{7'h00, 7'h01, 7'h02, 7'h03, 7'h04, 7'h05,
                             7'h10, 7'h11, 7'h20, 7'h21, 7'h22, 7'h23,
                             7'h24, 7'h28, 7'h01};

  initial begin
    reset = 1; opc = 7'h00; opd1 = 0; opd2 = 0; opd3 = 0;
    {C, V, S, Z_det} = 4'd0;
    {mc, mv, ms, mz} = 4'd0;
    m_ill = 0;
    apply_reset(2);

    run_instr(7'h00, 3'd3, 3'd1, 3'd2);
    force_z = 1; run_instr(7'h01, 3'd4, 3'd4, 3'd4);
    force_z = -1; run_instr(7'h20, 3'd0, 3'd5, 3'd0);
    force_z = 0; run_instr(7'h01, 3'd4, 3'd2, 3'd1);
    force_z = -1; run_instr(7'h20, 3'd0, 3'd5, 3'd0);
    run_instr(7'h10, 3'd1, 3'd2, 3'd0);
    run_instr(7'h11, 3'd5, 3'd3, 3'd0);
    run_instr(7'h28, 3'd0, 3'd6, 3'd0);

    for (int n = 0; n < 200; n++)
      run_instr(legal[$urandom_range(0, 14)], 3'($urandom),
                3'($urandom), 3'($urandom));

    run_instr(7'h7F, 3'd0, 3'd0, 3'd0);
    for (int i = 0; i < 20; i++) do_cycle(31, 31);
    apply_reset(1);

    run_instr(7'h40, 3'd0, 3'd0, 3'd0);
    for (int i = 0; i < 3; i++) do_cycle(31, 31);
    apply_reset(1);

    opc = 7'h10; opd1 = 3'd6; opd2 = 3'd1; opd3 = 3'd0;
    for (int i = 0; i < 4; i++) do_cycle(i, i + 1);
    do_cycle(4, 7);
    do_cycle(7, 8);
    do_cycle(8, 9);
    reset = 1;
    #1;
    check("ld3_state", 32'(state), 32'd9);
    check("ld3_next", 32'(next_state), 32'd0);
    check("ld3_strobes", 32'(obs_strb()), 32'd0);
    @(negedge clk);
    check("ld3_after", 32'(state), 32'd0);
    reset = 0;
    {mc, mv, ms, mz} = 4'd0;
    m_ill = 0;
    run_instr(7'h00, 3'd3, 3'd1, 3'd2);
    run_instr(7'h10, 3'd6, 3'd1, 3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_control_unit.md
# cpu_control_unit

Multi-cycle Moore controller for the 16-bit single-cycle-bus CPU. It sits directly upstream of `CPU_datapath` and owns the CPU state register. It consumes the datapath's `opc` and ALU flags, and drives every datapath load/read/write strobe, register address, ALU function select and `next_state`, so a program held in `rom_mem0..19` runs with no bench-driven control.

## Interface
- No parameters. State, opcode and `fsel` encodings are fixed in `cpu_pkg`.
- `clk`  in  1  — rising-edge clock.
- `reset`  in  1  — synchronous, active-high.
- `opc`  in  7  — IR[15:9], from the datapath.
- `opd1`, `opd2`, `opd3`  in  3 each  — IR[8:6], IR[5:3], IR[2:0].
- `C`, `V`, `S`, `Z_det`  in  1 each  — live ALU flags.
- `ldPC`, `ldIR`, `ldMAR`, `rd_mem`, `wr_mem`, `ldtmp`, `ldMDRZ`, `ldMDRdata`, `wr_reg`, `rd_reg`, `ldALU`  out  1 each  — datapath strobes.
- `ldXPC`, `ldYPC`, `ldXtmp`, `ldYtmp`, `ldXreg`, `ldYreg`, `ldXmem`, `ldYmem`, `ldXtmp2`, `ldYtmp2`  out  1 each  — ALU X/Y operand selects.
- `wr_regA`, `rd_regA`  out  3 each  — register-file write and read addresses.
- `fsel`  out  3  — ALU function: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 PASSX, 7 INC.
- `state`  out  5  — current state.
- `next_state`  out  5  — to the datapath's `next_state` input.
- `halted`  out  1  — high in HALT.
- `illegal_op`  out  1  — sticky; set on entry to HALT via an undefined opcode.

## Operation
- Opcodes:
  - ALU ops ADD..NOT are 0x00–0x05; `fsel` = opc[2:0].
  - LD 0x10, ST 0x11, BZ 0x20, BNZ 0x21, BC 0x22, BV 0x23, BS 0x24, JMP 0x28, HLT 0x7F.
  - Every other opcode is illegal.
- State codes and asserted outputs (unlisted outputs are 0; unlisted addresses are 0):
  - FETCH0 (0): ldXPC, fsel=6, ldALU.
  - FETCH1 (1): ldMAR, rd_mem.
  - FETCH2 (2): rd_mem, ldMDRdata, ldXPC, fsel=7, ldALU.
  - FETCH3 (3): ldIR, ldPC.
  - DECODE (4): rd_reg, rd_regA=opd2, ldtmp. Dispatches on `opc`.
  - ALU1 (5): rd_reg, rd_regA=opd3, ldXtmp, ldYreg, fsel=opc[2:0], ldALU.
  - ALU2 (6): wr_reg, wr_regA=opd1. Captures C/V/S/Z_det into the internal flag register.
  - LD1 (7): ldXtmp, fsel=6, ldALU.
  - LD2 (8): ldMAR, rd_mem.
  - LD3 (9): rd_mem, ldMDRdata.
  - LD4 (10): wr_reg, wr_regA=opd1.
  - ST1 (11): same outputs as LD1.
  - ST2 (12): ldMAR, rd_reg, rd_regA=opd1, ldXreg, fsel=6, ldALU.
  - ST3 (13): ldMDRZ.
  - ST4 (14): wr_mem.
  - BR1 (15): ldXPC, ldYtmp, fsel=0, ldALU. Target = PC+reg[opd2].
  - BR2 (16): ldPC.
  - JMP1 (17): ldXtmp, fsel=6, ldALU.
  - HALT (31): all strobes 0.
- Transitions:
  - FETCH0→1→2→3→DECODE.
  - ALU2, LD4, ST4 and BR2 go to FETCH0.
  - ALU1→ALU2; LD1..LD4 and ST1..ST4 step in order; BR1→BR2; JMP1→BR2.
  - HALT→HALT until `reset`.
- DECODE dispatch:
  - ALU op→ALU1, LD→LD1, ST→ST1, JMP→JMP1, HLT→HALT.
  - Branch taken→BR1; branch not taken→FETCH0.
  - Illegal opcode→HALT and sets `illegal_op`.
- Branch conditions use the captured flag register only, never the live flags (FETCH INC clobbers them):
  - BZ Z=1, BNZ Z=0, BC C=1, BV V=1, BS S=1.
- LD and ST do not update the flag register.
- Unused selects (`ldYPC`, `ldXmem`, `ldYmem`, `ldXtmp2`, `ldYtmp2`) are tied 0 in this ISA revision.

## Timing
- `state` is registered; all other outputs, including `next_state`, are combinational decodes of `state` plus DECODE inputs.
- Reset:
  - While `reset`=1, every strobe and select is forced 0 and `next_state`=0.
  - On the first edge with `reset` high: `state`=FETCH0, flag register=0, `illegal_op`=0.
  - Reset takes priority in any state, mid-instruction included; a partially executed LD/ST is abandoned with no `wr_reg`/`wr_mem` pulse.
- Instruction latency in cycles, FETCH0 to the next FETCH0:
  - ALU 7; LD 9; ST 9.
  - Branch taken 7; branch not taken 5; JMP 7.
- Each strobe is high for exactly one cycle per listed state.
- `wr_mem` and `wr_reg` are never high in the same cycle.

## Structure
- `cpu_pkg` holds the state codes, opcode constants and `fsel` constants. Shared with the datapath and the benches.
- One sub-module, `cpu_branch_cond`, is combinational: it takes opc and the captured flags and outputs `taken`.
- The state register and flag register live in `cpu_control_unit`.

## Test plan
- Reset:
  - Assert `reset` for 2 cycles → all outputs 0 while high.
  - Release → `state` sequence 0,1,2,3,4.
  - `fsel` = 6, x, 7 in FETCH0/FETCH2; `ldIR` and `ldPC` high only in state 3.
- ADD r3,r1,r2 (0x00CA): states 4→5→6→0.
  - In 5: rd_regA=2, fsel=0.
  - In 6: wr_reg=1, wr_regA=3.
  - Total 7 cycles.
- Flags and branch:
  - SUB giving Z_det=1 in ALU2, then BZ → states 4,15,16,0.
  - Same with Z=0 → 4,0.
  - Toggling live Z_det during FETCH does not change the decision.
- LD/ST:
  - LD (0x2050): wr_regA=1 in state 10, 9 cycles total.
  - ST: wr_mem pulses once, in state 14 only, with rd_regA=opd1 in state 12.
- Halt and illegal:
  - opc=0x7F → state 31, halted=1, illegal_op=0, held for 20 cycles.
  - opc=0x40 → state 31, illegal_op=1.
  - Reset → illegal_op=0, state 0.
- Reset in state 9 (LD3) → next state 0, no wr_reg pulse, normal fetch resumes.
